// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl: programmable clock divider with counted runs, drain-on-stop
// and reconfiguration that takes effect only at a period boundary.
module clock_div_ctrl #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [DIV_W-1:0] cfg_half,
   input  logic [CNT_W-1:0] cfg_count,
   input  logic             start,
   input  logic             stop,
   output logic             clk_out,
   output logic             tick,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_n;
   logic [DIV_W-1:0] cnt, cnt_n, h_act, h_act_n, h_pend, h_pend_n, cfg_h;
   logic [CNT_W-1:0] per, per_n, n_act, n_act_n, n_pend, n_pend_n, per_inc;
   logic pend, pend_n, clk_out_n, tick_n, busy_n, done_n, cfg_ready_n;
   logic xfer, wrap, fall, term, go_idle;
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         per       <= '0;
         pend      <= 1'b0;
         h_act     <= DIV_W'(1);
         n_act     <= '0;
         h_pend    <= '0;
         n_pend    <= '0;
         clk_out   <= 1'b0;
         tick      <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         cfg_ready <= 1'b1;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         per       <= per_n;
         pend      <= pend_n;
         h_act     <= h_act_n;
         n_act     <= n_act_n;
         h_pend    <= h_pend_n;
         n_pend    <= n_pend_n;
         clk_out   <= clk_out_n;
         tick      <= tick_n;
         done      <= done_n;
         busy      <= busy_n;
         cfg_ready <= cfg_ready_n;
      end
   end
   always_comb begin
      xfer      = cfg_valid & cfg_ready;
      cfg_h     = (cfg_half == '0) ? DIV_W'(1) : cfg_half;
      wrap      = cnt == h_act - DIV_W'(1);
      fall      = wrap & clk_out;
      per_inc   = per + CNT_W'(1);
      term      = (state == RUN) & fall & (n_act != '0) & (per_inc == n_act);
      state_n   = state;
      cnt_n     = cnt;
      per_n     = per;
      pend_n    = pend;
      h_act_n   = h_act;
      n_act_n   = n_act;
      h_pend_n  = h_pend;
      n_pend_n  = n_pend;
      clk_out_n = clk_out;
      tick_n    = 1'b0;
      done_n    = 1'b0;
      go_idle   = 1'b0;
      if (state == IDLE) begin
         if (xfer) begin
            h_act_n = cfg_h;
            n_act_n = cfg_count;
         end
         if (start & ~stop) begin
            state_n   = RUN;
            cnt_n     = '0;
            per_n     = '0;
            clk_out_n = 1'b0;
         end
      end else begin
         cnt_n     = wrap ? '0 : cnt + DIV_W'(1);
         clk_out_n = clk_out ^ wrap;
         tick_n    = wrap & ~clk_out;
         if (fall) per_n = per_inc;
         // pending config swaps in on the falling edge, restarting the period count
         if (fall & pend) begin
            h_act_n = h_pend;
            n_act_n = n_pend;
            pend_n  = 1'b0;
            per_n   = '0;
         end
         if ((state == RUN) & xfer) begin
            h_pend_n = cfg_h;
            n_pend_n = cfg_count;
            pend_n   = 1'b1;
         end
         if ((state == RUN) & stop & clk_out & ~fall) state_n = DRAIN;
         go_idle = term | ((state == DRAIN) & fall) | ((state == RUN) & stop & (~clk_out | fall));
         done_n  = term;
      end
      // leaving a run drops any pending config and forces the output low
      if (go_idle) begin
         state_n   = IDLE;
         cnt_n     = '0;
         per_n     = '0;
         pend_n    = 1'b0;
         h_act_n   = h_act;
         n_act_n   = n_act;
         clk_out_n = 1'b0;
         tick_n    = 1'b0;
      end
      busy_n      = state_n != IDLE;
      cfg_ready_n = (state_n == IDLE) | ((state_n == RUN) & ~pend_n);
   end
endmodule

// File: tb/tb_clock_div_ctrl.sv
// tb_clock_div_ctrl: directed literal scenarios plus random traffic, checked every
// cycle against a period-position model of the divider.
module tb_clock_div_ctrl;
   localparam int DW = 8;
   localparam int CW = 8;
   logic clk_in = 1'b0, rst = 1'b1, cfg_valid = 1'b0, start = 1'b0, stop = 1'b0;
   logic [DW-1:0] cfg_half = '0;
   logic [CW-1:0] cfg_count = '0;
   logic cfg_ready, clk_out, tick, busy, done;
   int errors = 0, checks = 0;
   always #5 clk_in = ~clk_in;
   clock_div_ctrl #(.DIV_W(DW), .CNT_W(CW)) dut (
      .clk_in(clk_in), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_half(cfg_half), .cfg_count(cfg_count), .start(start), .stop(stop),
      .clk_out(clk_out), .tick(tick), .busy(busy), .done(done));
   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask
   // model: ms 0=idle 1=run 2=drain; t = cycles into the current output period
   int ms = 0, t = 0, h = 1, n = 0, per = 0, ph = 1, pn = 0;
   bit pf = 0, e_tick = 0, e_done = 0, model_ok = 0;
   always @(posedge clk_in) begin
      int hv, nt;
      bit xfer, endp, rise, hi, term, idle_go;
      if (rst) begin
         ms = 0; t = 0; h = 1; n = 0; per = 0; pf = 0; e_tick = 0; e_done = 0;
      end else begin
         xfer = cfg_valid && (ms == 0 || (ms == 1 && !pf));
         hv = (cfg_half == 0) ? 1 : int'(cfg_half);
         e_tick = 0;
         e_done = 0;
         if (ms == 0) begin
            if (xfer) begin h = hv; n = int'(cfg_count); end
            if (start && !stop) begin ms = 1; t = 0; per = 0; end
         end else begin
            nt = t + 1;
            endp = nt == 2 * h;
            rise = nt == h;
            hi = t >= h;
            term = ms == 1 && endp && n != 0 && ((per + 1) % 256) == n;
            idle_go = term || (ms == 2 && endp) || (ms == 1 && stop && (!hi || endp));
            if (idle_go) begin
               ms = 0; t = 0; pf = 0; e_done = term;
            end else begin
               if (ms == 1 && stop) ms = 2;
               t = endp ? 0 : nt;
               e_tick = rise;
               if (endp) begin
                  per = (per + 1) % 256;
                  if (pf) begin h = ph; n = pn; pf = 0; per = 0; end
               end
               if (xfer) begin ph = hv; pn = int'(cfg_count); pf = 1; end
            end
         end
      end
      model_ok = 1;
   end
   always @(negedge clk_in) begin
      if (model_ok) begin
         chk("m_clk_out", clk_out, (ms != 0 && t >= h));
         chk("m_tick", tick, e_tick);
         chk("m_done", done, e_done);
         chk("m_busy", busy, ms != 0);
         chk("m_cfg_ready", cfg_ready, (ms == 0 || (ms == 1 && !pf)));
      end
   end
   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask
   task automatic idle_in();
      cfg_valid = 0; start = 0; stop = 0;
   endtask
   task automatic launch(input int hh, input int nn);
      cfg_valid = 1; cfg_half = DW'(hh); cfg_count = CW'(nn); start = 1;
   endtask
   task automatic wait_high();
      int k = 0;
      @(negedge clk_in);
      while (!clk_out && k < 600) begin @(negedge clk_in); k++; end
      chk("wait_high", clk_out, 1);
   endtask
   task automatic wait_idle();
      int k = 0;
      @(negedge clk_in);
      while (busy && k < 2000) begin @(negedge clk_in); k++; end
      chk("wait_idle", busy, 0);
   endtask
   initial begin
      logic [3:0] e;
      repeat (3) @(posedge clk_in);
      #1 rst = 0;
      cyc();
      launch(4, 2);
      for (int i = 0; i < 19; i++) begin
         @(negedge clk_in);
         e = {(i >= 5 && i <= 8) || (i >= 13 && i <= 16), i == 5 || i == 13, i == 17, i >= 1 && i <= 16};
         chk("h4n2_trace", {clk_out, tick, done, busy}, e);
         cyc();
         idle_in();
      end
      launch(0, 0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_in);
         e = {1'b0, i >= 1 && i % 2 == 0, 1'b0, i >= 1};
         chk("h0_freerun", {clk_out, done, busy}, e[2:0]);
         cyc();
         idle_in();
      end
      stop = 1;
      cyc();
      idle_in();
      wait_idle();
      cyc();
      start = 1; stop = 1;
      cyc();
      idle_in();
      @(negedge clk_in);
      chk("start_stop_idle", busy, 0);
      cyc();
      launch(3, 0);
      cyc();
      idle_in();
      wait_high();
      rst = 1;
      cyc();
      rst = 0;
      @(negedge clk_in);
      chk("rst_mid_run", {clk_out, busy, cfg_ready}, 3'b001);
      cyc();
      launch(3, 0);
      cyc();
      idle_in();
      wait_high();
      stop = 1;
      cyc();
      stop = 0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk_in);
         chk("drain", {clk_out, busy, done}, (k < 3) ? 3'b110 : 3'b000);
         cyc();
      end
      launch(4, 0);
      cyc();
      idle_in();
      wait_high();
      cfg_valid = 1; cfg_half = 2; cfg_count = 0;
      cyc();
      cfg_valid = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_in);
         if (k == 1) chk("pend_ready_drop", cfg_ready, 0);
         else chk("reconfig", {clk_out, cfg_ready}, {k <= 3 || k == 6 || k == 7, k >= 4});
         cyc();
      end
      stop = 1;
      cyc();
      idle_in();
      wait_idle();
      cyc();
      launch(2, 1);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk_in);
         e = {i == 3 || i == 4, i == 3, i == 5, i >= 1 && i <= 4};
         chk("n1_stop_term", {clk_out, tick, done, busy}, e);
         cyc();
         idle_in();
         if (i == 3) stop = 1;
      end
      repeat (3000) begin
         cyc();
         rst = $urandom_range(0, 299) == 0;
         cfg_valid = $urandom_range(0, 3) == 0;
         cfg_half = ($urandom_range(0, 9) == 0) ? DW'($urandom_range(0, 20)) : DW'($urandom_range(0, 4));
         cfg_count = CW'($urandom_range(0, 3));
         start = $urandom_range(0, 5) == 0;
         stop = $urandom_range(0, 39) == 0;
      end
      cyc();
      idle_in();
      rst = 0;
      repeat (2) @(negedge clk_in);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
